// File: rtl/chu_frac_pkg.sv
// Shared constants and types for the queued fractal Avalon slave:
// register addresses, STATUS/CTRL bit positions, dispatcher states, command entry layout.
package chu_frac_pkg;

  localparam int TAG_W = 8;

  localparam logic [2:0] ADDR_CX     = 3'd0;
  localparam logic [2:0] ADDR_CY     = 3'd1;
  localparam logic [2:0] ADDR_MAX_IT = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_RESULT = 3'd5;

  localparam int STAT_CMD_FULL    = 0;
  localparam int STAT_CMD_EMPTY   = 1;
  localparam int STAT_RES_FULL    = 2;
  localparam int STAT_RES_EMPTY   = 3;
  localparam int STAT_BUSY        = 4;
  localparam int STAT_OVERFLOW    = 5;
  localparam int STAT_CMD_CNT_LSB = 8;
  localparam int STAT_RES_CNT_LSB = 16;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int RES_VALID   = 31;
  localparam int RES_TAG_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frac_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      cx;
    logic [31:0]      cy;
  } cmd_entry_t;

endpackage

// File: rtl/chu_sync_fifo.sv
// Synchronous FIFO with clear, full/empty/count flags and same-cycle push+pop.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module chu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Clear outranks any push or pop presented in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/chu_avalon_frac_queue.sv
// Avalon-MM slave feeding queued (cx, cy) points to one frac_engine and queuing tagged results.
// Optional level interrupt is built only when CHU_FRAC_IRQ_EN is defined.
module chu_avalon_frac_queue #(
  parameter int DEPTH      = 16,
  parameter int ITER_W     = 16,
  parameter int IRQ_THRESH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        frac_address,
  input  logic              frac_chipselect,
  input  logic              frac_write,
  input  logic              frac_read,
  input  logic [31:0]       frac_writedata,
  output logic [31:0]       frac_readdata,
  output logic              frac_irq,
  output logic              eng_start,
  output logic [31:0]       eng_cx,
  output logic [31:0]       eng_cy,
  output logic [ITER_W-1:0] eng_max_it,
  input  logic              eng_ready,
  input  logic              eng_done_tick,
  input  logic [ITER_W-1:0] eng_iter
);

  import chu_frac_pkg::*;

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CMD_W = $bits(cmd_entry_t);
  localparam int RES_W = TAG_W + ITER_W;

  if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..128");
  end
  if (ITER_W < 1 || ITER_W > 16) begin : g_bad_iter_w
    $error("ITER_W must be in 1..16");
  end
  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_irq_thresh
    $error("IRQ_THRESH must be in 1..DEPTH");
  end

  logic              wr;
  logic              rd;
  logic              clear;
  logic              cy_wr;
  logic [31:0]       cx_stage;
  logic [TAG_W-1:0]  tag;
  logic [ITER_W-1:0] max_it_reg;
  logic              overflow;
  logic              irq_en;

  logic              cmd_push;
  logic              cmd_full;
  logic              cmd_empty;
  logic [CW-1:0]     cmd_count;
  cmd_entry_t        cmd_wdata;
  logic [CMD_W-1:0]  cmd_rdata;
  cmd_entry_t        cmd_head;

  logic              res_push;
  logic              res_pop;
  logic              res_full;
  logic              res_empty;
  logic [CW-1:0]     res_count;
  logic [RES_W-1:0]  res_wdata;
  logic [RES_W-1:0]  res_rdata;

  frac_state_e       state;
  frac_state_e       state_nx;
  logic              dispatch;
  logic [TAG_W-1:0]  job_tag;

  assign wr       = frac_chipselect & frac_write;
  assign rd       = frac_chipselect & frac_read;
  assign clear    = wr && (frac_address == ADDR_CTRL) && frac_writedata[CTRL_CLEAR];
  assign cy_wr    = wr && (frac_address == ADDR_CY);
  assign cmd_push = cy_wr && !cmd_full;
  assign res_pop  = rd && (frac_address == ADDR_RESULT) && !res_empty && !clear;

  assign cmd_wdata = '{tag: tag, cx: cx_stage, cy: frac_writedata};
  assign cmd_head  = cmd_entry_t'(cmd_rdata);
  assign res_wdata = {job_tag, eng_iter};

  // A CY write that finds the FIFO full is dropped without consuming a tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_stage   <= '0;
      max_it_reg <= '0;
      tag        <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr && (frac_address == ADDR_CX))     cx_stage   <= frac_writedata;
      if (wr && (frac_address == ADDR_MAX_IT)) max_it_reg <= frac_writedata[ITER_W-1:0];
      if (clear) begin
        tag      <= '0;
        overflow <= 1'b0;
      end else begin
        if (cmd_push)          tag      <= tag + 1'b1;
        if (cy_wr && cmd_full) overflow <= 1'b1;
      end
    end
  end

`ifdef CHU_FRAC_IRQ_EN
  localparam logic [CW-1:0] IRQ_LVL = CW'(IRQ_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_en <= 1'b0;
    else if (wr && (frac_address == ADDR_CTRL)) irq_en <= frac_writedata[CTRL_IRQ_EN];
  end

  assign frac_irq = irq_en & ((res_count >= IRQ_LVL) | overflow);
`else
  assign irq_en   = 1'b0;
  assign frac_irq = 1'b0;
`endif

  chu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (cmd_push),
    .pop     (dispatch),
    .wdata   (cmd_wdata),
    .rdata   (cmd_rdata),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (cmd_count)
  );

  chu_sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (res_push),
    .pop     (res_pop),
    .wdata   (res_wdata),
    .rdata   (res_rdata),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // A done_tick coinciding with clear still ends the job, so RUN returns to IDLE rather than DRAIN.
  always_comb begin
    state_nx = state;
    dispatch = 1'b0;
    res_push = 1'b0;
    case (state)
      IDLE: begin
        if (!clear && !cmd_empty && !res_full && eng_ready) begin
          dispatch = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (eng_done_tick) begin
          res_push = !clear;
          state_nx = IDLE;
        end else if (clear) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (eng_done_tick) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_start  <= 1'b0;
      eng_cx     <= '0;
      eng_cy     <= '0;
      eng_max_it <= '0;
      job_tag    <= '0;
    end else begin
      eng_start <= dispatch;
      if (dispatch) begin
        eng_cx     <= cmd_head.cx;
        eng_cy     <= cmd_head.cy;
        eng_max_it <= max_it_reg;
        job_tag    <= cmd_head.tag;
      end
    end
  end

  always_comb begin
    frac_readdata = '0;
    case (frac_address)
      ADDR_MAX_IT: frac_readdata[ITER_W-1:0] = max_it_reg;
      ADDR_CTRL:   frac_readdata[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        frac_readdata[STAT_CMD_FULL]              = cmd_full;
        frac_readdata[STAT_CMD_EMPTY]             = cmd_empty;
        frac_readdata[STAT_RES_FULL]              = res_full;
        frac_readdata[STAT_RES_EMPTY]             = res_empty;
        frac_readdata[STAT_BUSY]                  = (state != IDLE);
        frac_readdata[STAT_OVERFLOW]              = overflow;
        frac_readdata[STAT_CMD_CNT_LSB +: 8]      = 8'(cmd_count);
        frac_readdata[STAT_RES_CNT_LSB +: 8]      = 8'(res_count);
      end
      ADDR_RESULT: begin
        if (!res_empty) begin
          frac_readdata[RES_VALID]                = 1'b1;
          frac_readdata[RES_TAG_LSB +: TAG_W]     = res_rdata[RES_W-1 -: TAG_W];
          frac_readdata[15:0]                     = 16'(res_rdata[ITER_W-1:0]);
        end
      end
      default: frac_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_avalon_frac_queue.sv
// Self-checking bench for chu_avalon_frac_queue: engine model, point/result reference queues,
// RESULT-read monitor and directed scenarios followed by a randomized phase.
module tb_chu_avalon_frac_queue;
  import chu_frac_pkg::*;

  localparam int DEPTH      = 16;
  localparam int ITER_W     = 16;
  localparam int IRQ_THRESH = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        frac_address;
  logic              frac_chipselect;
  logic              frac_write;
  logic              frac_read;
  logic [31:0]       frac_writedata;
  logic [31:0]       frac_readdata;
  logic              frac_irq;
  logic              eng_start;
  logic [31:0]       eng_cx;
  logic [31:0]       eng_cy;
  logic [ITER_W-1:0] eng_max_it;
  logic              eng_ready;
  logic              eng_done_tick;
  logic [ITER_W-1:0] eng_iter;

  chu_avalon_frac_queue #(.DEPTH(DEPTH), .ITER_W(ITER_W), .IRQ_THRESH(IRQ_THRESH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frac_address    (frac_address),
    .frac_chipselect (frac_chipselect),
    .frac_write      (frac_write),
    .frac_read       (frac_read),
    .frac_writedata  (frac_writedata),
    .frac_readdata   (frac_readdata),
    .frac_irq        (frac_irq),
    .eng_start       (eng_start),
    .eng_cx          (eng_cx),
    .eng_cy          (eng_cy),
    .eng_max_it      (eng_max_it),
    .eng_ready       (eng_ready),
    .eng_done_tick   (eng_done_tick),
    .eng_iter        (eng_iter)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] cx;
    logic [31:0] cy;
  } pt_t;

  pt_t         cmd_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  m_tag = '0;
  logic        m_ovf = 1'b0;
  logic        m_irq_en = 1'b0;
  logic [15:0] m_max_it = '0;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int last_cy_cyc = 0;
  int eng_lat = 10;
  logic eng_stall;
  logic eng_busy_m;

  assign eng_ready = !eng_stall && !eng_busy_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cmd_n, input int res_n, input logic busy);
    logic [31:0] s;
    s = '0;
    s[0]     = (cmd_n == DEPTH);
    s[1]     = (cmd_n == 0);
    s[2]     = (res_n == DEPTH);
    s[3]     = (res_n == 0);
    s[4]     = busy;
    s[5]     = m_ovf;
    s[15:8]  = 8'(cmd_n);
    s[23:16] = 8'(res_n);
    return s;
  endfunction

  function automatic logic exp_irq(input int res_n);
`ifdef CHU_FRAC_IRQ_EN
    return m_irq_en && ((res_n >= IRQ_THRESH) || m_ovf);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- bus driver tasks ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    frac_address = a; frac_writedata = d; frac_chipselect = 1'b1; frac_write = 1'b1;
    if (a == ADDR_CY) last_cy_cyc = cyc;
    @(posedge clk); #1;
    frac_chipselect = 1'b0; frac_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    frac_address = a; frac_chipselect = 1'b1; frac_read = 1'b1;
    @(negedge clk);
    d = frac_readdata;
    @(posedge clk); #1;
    frac_chipselect = 1'b0; frac_read = 1'b0;
  endtask

  task automatic push_point(input logic [31:0] cx, input logic [31:0] cy);
    pt_t p;
    bus_write(ADDR_CX, cx);
    if (cmd_q.size() < DEPTH) begin
      p.cx = cx; p.cy = cy;
      cmd_q.push_back(p);
      exp_q.push_back({1'b1, 7'd0, m_tag, cy[15:0]});
      m_tag++;
    end else begin
      m_ovf = 1'b1;
    end
    bus_write(ADDR_CY, cy);
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    if (d[0]) begin
      cmd_q.delete(); exp_q.delete(); m_tag = '0; m_ovf = 1'b0;
    end
    m_irq_en = d[1];
    bus_write(ADDR_CTRL, d);
  endtask

  task automatic write_max_it(input logic [15:0] v);
    m_max_it = v;
    bus_write(ADDR_MAX_IT, {16'd0, v});
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (start_cnt < n && k < budget) begin @(posedge clk); #1; k++; end
    check(name, 32'(start_cnt >= n), 32'd1);
  endtask

  task automatic wait_engine_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((eng_busy_m || cmd_q.size() != 0) && k < budget) begin @(posedge clk); #1; k++; end
    repeat (2) begin @(posedge clk); #1; end
    check(name, 32'(k < budget), 32'd1);
  endtask

  task automatic drain_results(input int budget, input string name);
    int k;
    logic [31:0] d;
    k = 0;
    eng_stall = 1'b0;
    while (exp_q.size() > 0 && k < budget) begin bus_read(ADDR_RESULT, d); k++; end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- engine model ----------------
  initial begin
    pt_t p;
    logic [15:0] iter_v;
    eng_busy_m    = 1'b0;
    eng_done_tick = 1'b0;
    eng_iter      = '0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (cmd_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          p = cmd_q.pop_front();
          check("eng_cx", eng_cx, p.cx);
          check("eng_cy", eng_cy, p.cy);
        end
        check("eng_max_it", 32'(eng_max_it), 32'(m_max_it));
        eng_busy_m = 1'b1;
        iter_v = eng_cy[15:0];
        @(negedge clk);
        check("start_pulse_width", 32'(eng_start), 32'd0);
        repeat (eng_lat - 1) @(negedge clk);
        eng_iter      = iter_v;
        eng_done_tick = 1'b1;
        @(negedge clk);
        eng_done_tick = 1'b0;
        eng_busy_m    = 1'b0;
      end
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (frac_chipselect && frac_read && frac_address == ADDR_RESULT && frac_readdata[31]) begin
        if (exp_q.size() == 0) begin
          check("result_unexpected", frac_readdata, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", frac_readdata, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int base;
    reset_n = 1'b0; eng_stall = 1'b0;
    frac_address = '0; frac_chipselect = 1'b0; frac_write = 1'b0; frac_read = 1'b0;
    frac_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_cx", eng_cx, 32'd0);
    check("rst_eng_max_it", 32'(eng_max_it), 32'd0);
    check("rst_irq", 32'(frac_irq), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(ADDR_STATUS, d); check("rst_status", d, exp_status(0, 0, 1'b0));
    bus_read(ADDR_RESULT, d); check("rst_result", d, 32'd0);
    bus_read(ADDR_MAX_IT, d); check("rst_max_it", d, 32'd0);

    // three points, engine latency 10
    eng_lat = 10;
    push_point(32'h0000_0100, 32'd5);
    wait_starts(1, 20, "first_start");
    check("start_latency", 32'(last_start_cyc - last_cy_cyc), 32'd2);
    push_point(32'h0000_0101, 32'd9);
    push_point(32'h0000_0102, 32'd200);
    wait_engine_idle(200, "three_jobs_idle");
    bus_read(ADDR_RESULT, d); check("res0", d, 32'h8000_0005);
    bus_read(ADDR_RESULT, d); check("res1", d, 32'h8001_0009);
    bus_read(ADDR_RESULT, d); check("res2", d, 32'h8002_00C8);
    bus_read(ADDR_RESULT, d); check("res_empty_read", d, 32'h0000_0000);

    // overflow with stalled engine, then result FIFO back-pressure
    eng_stall = 1'b1;
    eng_lat = 3;
    for (int i = 0; i < 17; i++) push_point(32'h1000 + i, 32'h4000 + i);
    bus_read(ADDR_STATUS, d); check("status_overflow", d, exp_status(16, 0, 1'b0));
    base = start_cnt;
    eng_stall = 1'b0;
    wait_starts(base + 16, 400, "sixteen_starts");
    wait_engine_idle(100, "sixteen_idle");
    check("no_17th_dispatch", 32'(start_cnt), 32'(base + 16));
    push_point(32'h2000, 32'h0AAA);
    push_point(32'h2001, 32'h0BBB);
    repeat (30) begin @(posedge clk); #1; end
    check("no_start_res_full", 32'(start_cnt), 32'(base + 16));
    bus_read(ADDR_STATUS, d); check("status_res_full", d, exp_status(2, 16, 1'b0));
    bus_read(ADDR_RESULT, d);
    wait_starts(base + 17, 20, "start_after_pop");
    drain_results(200, "drain_backpressure");

    // clear while a job is running
    write_ctrl(32'h1);
    eng_lat = 10;
    push_point(32'h3000, 32'h0111);
    push_point(32'h3001, 32'h0222);
    base = start_cnt;
    wait_starts(base + 1, 20, "clear_job_start");
    repeat (3) begin @(posedge clk); #1; end
    write_ctrl(32'h1);
    bus_read(ADDR_STATUS, d); check("status_drain", d, exp_status(0, 0, 1'b1));
    wait_engine_idle(50, "drain_idle");
    bus_read(ADDR_STATUS, d); check("status_after_drain", d, exp_status(0, 0, 1'b0));
    bus_read(ADDR_RESULT, d); check("drained_result_gone", d, 32'd0);
    eng_lat = 3;
    push_point(32'h0000_0077, 32'h0000_1234);
    wait_engine_idle(50, "tag_restart_idle");
    bus_read(ADDR_RESULT, d); check("tag_restart", d, 32'h8000_1234);

    // MAX_IT changes while running apply to the next dispatch only
    eng_lat = 10;
    write_max_it(16'd30);
    base = start_cnt;
    push_point(32'h5000, 32'h0055);
    wait_starts(base + 1, 20, "maxit_start");
    check("maxit_first", 32'(eng_max_it), 32'd30);
    bus_write(ADDR_MAX_IT, 32'd100);
    check("maxit_hold_100", 32'(eng_max_it), 32'd30);
    write_max_it(16'd50);
    check("maxit_hold_50", 32'(eng_max_it), 32'd30);
    bus_read(ADDR_MAX_IT, d); check("maxit_readback", d, 32'd50);
    push_point(32'h5001, 32'h0066);
    wait_engine_idle(100, "maxit_idle");
    check("maxit_second", 32'(eng_max_it), 32'd50);
    drain_results(50, "drain_maxit");

    // interrupt threshold
    write_ctrl(32'h1);
    write_ctrl(32'h2);
    eng_lat = 3;
    check("irq_empty", 32'(frac_irq), 32'(exp_irq(0)));
    push_point(32'h6000, 32'h0001);
    wait_engine_idle(50, "irq_idle1");
    check("irq_one", 32'(frac_irq), 32'(exp_irq(1)));
    push_point(32'h6001, 32'h0002);
    wait_engine_idle(50, "irq_idle2");
    check("irq_two", 32'(frac_irq), 32'(exp_irq(2)));
    bus_read(ADDR_CTRL, d); check("ctrl_readback", d, {30'd0, exp_irq(DEPTH), 1'b0});
    bus_read(ADDR_RESULT, d);
    check("irq_after_pop", 32'(frac_irq), 32'(exp_irq(1)));
    drain_results(20, "drain_irq");

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      eng_lat = $urandom_range(1, 6);
      if (r <= 3) begin
        if (cmd_q.size() < DEPTH - 2) push_point($urandom, $urandom);
      end else if (r <= 6) begin
        bus_read(ADDR_RESULT, d);
      end else if (r == 7) begin
        eng_stall = ($urandom_range(0, 3) == 0);
      end else begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
    end
    drain_results(500, "drain_random");
    wait_engine_idle(50, "final_idle");
    bus_read(ADDR_STATUS, d); check("final_status", d, exp_status(0, 0, 1'b0));
    check("final_irq", 32'(frac_irq), 32'(exp_irq(0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chu_avalon_frac_queue.md
Name: chu_avalon_frac_queue

Overview:
Queued successor of the single-shot fractal Avalon-MM slave. Software loads a command FIFO with (cx, cy) points. An internal dispatcher FSM feeds the points one at a time to an external frac_engine through a start/done handshake. Each iteration count, with its sequence tag, goes into a result FIFO that software pops through the same Avalon slave. Sits between the Avalon fabric and one frac_engine instance; software no longer polls per point.

Parameters:
DEPTH, 16, entries in each FIFO; power of 2, 2..128
ITER_W, 16, iteration count width; 1..16
IRQ_THRESH, 8, result-FIFO occupancy that raises frac_irq; 1..DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
frac_address  in  3  Avalon word address
frac_chipselect  in  1  Avalon chip select
frac_write  in  1  Avalon write strobe
frac_read  in  1  Avalon read strobe (pop side effect)
frac_writedata  in  32  Avalon write data
frac_readdata  out  32  Avalon read data, zero read latency (combinational from address)
frac_irq  out  1  level interrupt (see Optional Feature)
eng_start  out  1  one-cycle start pulse to engine
eng_cx  out  32  job cx, stable while busy
eng_cy  out  32  job cy, stable while busy
eng_max_it  out  ITER_W  job max iterations, stable while busy
eng_ready  in  1  engine idle
eng_done_tick  in  1  one-cycle completion pulse
eng_iter  in  ITER_W  iteration result, valid with eng_done_tick

Behaviour:
- Register map (wr = write & chipselect, rd = read & chipselect):
  - 0 CX: write loads cx_stage.
  - 1 CY: write pushes {tag, cx_stage, writedata} into cmd FIFO, then tag increments (8-bit, wraps 255->0).
  - 2 MAX_IT: read/write, low ITER_W bits.
  - 3 CTRL: write with bit0=1 means clear.
  - 4 STATUS (read): bit0 cmd_full, bit1 cmd_empty, bit2 res_full, bit3 res_empty, bit4 busy, bit5 overflow; [15:8] cmd_count; [23:16] res_count.
  - 5 RESULT (read): bit31 valid, [30:24] 0, [23:16] tag, [15:0] iter zero-extended.
  - Addresses 6-7 read 0; writes to them are ignored.
- RESULT read with rd and result FIFO non-empty pops one entry in the same cycle; the returned data is the head entry before the pop.
- RESULT read while empty returns 0 (valid=0) and does not pop.
- CY push while cmd_full: data dropped, tag not incremented, overflow set. overflow is sticky and cleared only by clear or reset.
- Dispatcher FSM:
  - IDLE: if cmd not empty, res_count < DEPTH and eng_ready, pop cmd, latch cx/cy/tag, capture max_it_reg, pulse eng_start one cycle, go to RUN.
  - RUN: on eng_done_tick, push {tag, eng_iter} into result FIFO, go to IDLE. Next dispatch happens no earlier than the following cycle.
  - DRAIN: on eng_done_tick, discard result, go to IDLE.
- Only one job is ever in flight, and dispatch requires result-FIFO room, so a result push never overflows.
- MAX_IT write during RUN affects the next dispatch only.
- busy = (state != IDLE).
- Clear (any state): both FIFOs emptied, tag reset to 0, overflow cleared. RUN goes to DRAIN; IDLE and DRAIN keep their state.
- Clear takes priority over a simultaneous FSM push/pop or bus pop in the same cycle.
- Simultaneous FSM result push and bus pop: both take effect, res_count unchanged. Same for CY push and dispatch pop on the cmd FIFO.
- Reset values:
  - All registers, FIFOs, tag and overflow: 0.
  - state: IDLE.
  - eng_start, eng_cx, eng_cy, eng_max_it, frac_irq: 0.
- Latency: CY write at cycle t with the engine ready gives eng_start at t+2 (FIFO write t, FSM sees non-empty t+1, pulse t+2).

Optional Feature:
- Macro: CHU_FRAC_IRQ_EN.
- Defined:
  - frac_irq = irq_enable & (res_count >= IRQ_THRESH | overflow).
  - irq_enable is CTRL bit1, read back at address 3 bit1, reset 0.
- Undefined: frac_irq tied 0; CTRL bit1 ignored and reads 0; no threshold comparator synthesised.

Decomposition:
- Package chu_frac_pkg:
  - Address constants ADDR_CX..ADDR_RESULT.
  - STATUS/CTRL bit-position constants.
  - FSM state typedef {IDLE, RUN, DRAIN}.
  - TAG_W = 8.
- Sub-module chu_sync_fifo: parametrised width/depth, synchronous clear, full/empty/count outputs, same-cycle push+pop.
  - Instantiated twice: cmd FIFO width 72, result FIFO width 8+ITER_W.

Test Plan:
- Push 3 points (tags 0,1,2) with engine model returning iter 5,9,200 after 10 cycles each -> three RESULT reads return 0x80000005, 0x80010009, 0x800200C8, then a fourth read returns 0x00000000.
- 17 CY writes with engine stalled (eng_ready=0), DEPTH=16 -> STATUS cmd_count=16, cmd_full=1, overflow=1; the 17th point is never dispatched.
- Let 16 results accumulate without reading, with more commands queued -> no eng_start while res_count=16; one RESULT read triggers the next dispatch.
- Clear asserted 3 cycles after eng_start -> FSM enters DRAIN, busy=1 until done_tick, discarded result never appears, STATUS reads res_empty=1, cmd_empty=1, tag restarts at 0.
- Write MAX_IT=100 during RUN, then 50 before next dispatch -> eng_max_it holds its prior value until the next eng_start, which carries 50.
- With CHU_FRAC_IRQ_EN and IRQ_THRESH=2, CTRL=0x2 -> frac_irq rises the cycle res_count reaches 2 and falls after one pop; with the macro undefined, frac_irq stays 0 throughout.
